// File: rtl/hazard3_riscv_timer_mc.sv
// hazard3_riscv_timer_mc
//
// RISC-V machine timer with one shared 64-bit mtime and N_CMP mtimecmp
// comparators, each driving its own registered timer IRQ. The timebase is an
// external non-return-to-zero tick (every edge is one tick), divided by a
// programmable prescaler. All register accesses complete in one APB cycle.
//
// Optional build macro: HAZARD3_TIMER_ATOMIC_READ_EN
//   When defined, reading MTIME latches mtime[63:32] into a shadow register
//   and MTIMEH reads return that shadow, giving a coherent 64-bit snapshot.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   psel/penable/pwrite APB control
//   paddr[7:0]          APB byte address (bits [1:0] ignored)
//   pwdata[31:0]        APB write data
//   prdata[31:0]        APB read data, combinational from paddr
//   pready              always 1
//   pslverr             1 for unmapped addresses
//   dbg_halt            debug halt request
//   tick_nrz            asynchronous external timebase
//   timer_irq[N_CMP-1:0] per-channel timer interrupt (mtime >= mtimecmp[i])

// Simple flop-chain synchroniser, cleared by reset.
module hazard3_sync_1bit #(
  parameter int N_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i,
  output logic o
);

  logic [N_STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[N_STAGES-2:0], i};
    end
  end

  assign o = sync_reg[N_STAGES-1];

endmodule

module hazard3_riscv_timer_mc #(
  parameter int N_CMP      = 1,
  parameter int W_PRESCALE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [7:0]           paddr,
  input  logic [31:0]          pwdata,
  output logic [31:0]          prdata,
  output logic                 pready,
  output logic                 pslverr,
  input  logic                 dbg_halt,
  input  logic                 tick_nrz,
  output logic [N_CMP-1:0]     timer_irq
);

  // ---------------------------------------------------------------------
  // Address decode (word index = paddr[7:2])
  // ---------------------------------------------------------------------
  logic [5:0]       widx;
  logic             wr_en;
  logic             sel_ctrl;
  logic             sel_presc;
  logic             sel_mtime;
  logic             sel_mtimeh;
  logic             sel_irqstat;
  logic [N_CMP-1:0] sel_cmp_lo;
  logic [N_CMP-1:0] sel_cmp_hi;
  logic             mapped;
  logic             unused_paddr_lsbs;

  assign widx              = paddr[7:2];
  assign unused_paddr_lsbs = ^paddr[1:0];
  assign wr_en             = psel && penable && pwrite;

  assign sel_ctrl    = (widx == 6'd0);
  assign sel_presc   = (widx == 6'd1);
  assign sel_mtime   = (widx == 6'd2);
  assign sel_mtimeh  = (widx == 6'd3);
  assign sel_irqstat = (widx == 6'd20);

  genvar gi;
  generate
    for (gi = 0; gi < N_CMP; gi++) begin : g_dec
      assign sel_cmp_lo[gi] = (widx == 6'(4 + 2 * gi));
      assign sel_cmp_hi[gi] = (widx == 6'(5 + 2 * gi));
    end
  endgenerate

  assign mapped  = sel_ctrl | sel_presc | sel_mtime | sel_mtimeh | sel_irqstat
                 | (|sel_cmp_lo) | (|sel_cmp_hi);
  assign pslverr = !mapped;
  assign pready  = 1'b1;

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  logic                  en_reg;
  logic                  halt_stop_reg;
  logic [W_PRESCALE-1:0] prescale_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg        <= 1'b1;
      halt_stop_reg <= 1'b1;
      prescale_reg  <= '0;
    end else begin
      if (wr_en && sel_ctrl) begin
        en_reg        <= pwdata[0];
        halt_stop_reg <= pwdata[1];
      end
      if (wr_en && sel_presc) begin
        prescale_reg <= pwdata[W_PRESCALE-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Tick detection: both edges of the synchronised level count
  // ---------------------------------------------------------------------
  logic tick_sync;
  logic tick_prev_reg;
  logic tick;

  hazard3_sync_1bit #(
    .N_STAGES(2)
  ) u_tick_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (tick_nrz),
    .o     (tick_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_prev_reg <= 1'b0;
    end else begin
      tick_prev_reg <= tick_sync;
    end
  end

  assign tick = tick_sync != tick_prev_reg;

  // ---------------------------------------------------------------------
  // Prescaler and mtime
  // ---------------------------------------------------------------------
  logic                  inc_en;
  logic                  step;
  logic [W_PRESCALE-1:0] presc_cnt_reg;
  logic [W_PRESCALE-1:0] presc_cnt_next;
  logic [63:0]           mtime_reg;
  logic [63:0]           mtime_next;

  assign inc_en = en_reg && !(dbg_halt && halt_stop_reg);
  assign step   = tick && inc_en && (presc_cnt_reg == prescale_reg);

  always_comb begin
    presc_cnt_next = presc_cnt_reg;
    if (wr_en && sel_presc) begin
      presc_cnt_next = '0;
    end else if (tick && inc_en) begin
      presc_cnt_next = (presc_cnt_reg == prescale_reg) ? '0
                     : presc_cnt_reg + W_PRESCALE'(1);
    end
  end

  // A software write to either half takes priority over the increment, so
  // the written value is observed exactly and the other half is untouched.
  always_comb begin
    mtime_next = mtime_reg;
    if (wr_en && sel_mtime) begin
      mtime_next[31:0] = pwdata;
    end else if (wr_en && sel_mtimeh) begin
      mtime_next[63:32] = pwdata;
    end else if (step) begin
      mtime_next = mtime_reg + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_reg <= '0;
      mtime_reg     <= '0;
    end else begin
      presc_cnt_reg <= presc_cnt_next;
      mtime_reg     <= mtime_next;
    end
  end

  // ---------------------------------------------------------------------
  // MTIMEH read source
  // ---------------------------------------------------------------------
  logic [31:0] mtimeh_rdata;

`ifdef HAZARD3_TIMER_ATOMIC_READ_EN
  logic        rd_en;
  logic [31:0] mtimeh_shadow_reg;

  assign rd_en = psel && penable && !pwrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimeh_shadow_reg <= '0;
    end else if (wr_en && sel_mtimeh) begin
      mtimeh_shadow_reg <= pwdata;
    end else if (rd_en && sel_mtime) begin
      mtimeh_shadow_reg <= mtime_reg[63:32];
    end
  end

  assign mtimeh_rdata = mtimeh_shadow_reg;
`else
  assign mtimeh_rdata = mtime_reg[63:32];
`endif

  // ---------------------------------------------------------------------
  // Comparator channels
  // ---------------------------------------------------------------------
  logic [N_CMP-1:0][63:0] cmp_val;

  generate
    for (gi = 0; gi < N_CMP; gi++) begin : g_cmp
      logic [63:0] cmp_reg;
      logic        irq_reg;

      // Reset to all-ones so no channel fires out of reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cmp_reg <= '1;
          irq_reg <= 1'b0;
        end else begin
          if (wr_en && sel_cmp_lo[gi]) begin
            cmp_reg[31:0] <= pwdata;
          end
          if (wr_en && sel_cmp_hi[gi]) begin
            cmp_reg[63:32] <= pwdata;
          end
          irq_reg <= (mtime_reg >= cmp_reg);
        end
      end

      assign cmp_val[gi]   = cmp_reg;
      assign timer_irq[gi] = irq_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------
  always_comb begin
    prdata = 32'h0;
    if (sel_ctrl) begin
      prdata = {30'h0, halt_stop_reg, en_reg};
    end else if (sel_presc) begin
      prdata = 32'(prescale_reg);
    end else if (sel_mtime) begin
      prdata = mtime_reg[31:0];
    end else if (sel_mtimeh) begin
      prdata = mtimeh_rdata;
    end else if (sel_irqstat) begin
      prdata = 32'(timer_irq);
    end
    for (int i = 0; i < N_CMP; i++) begin
      if (sel_cmp_lo[i]) begin
        prdata = cmp_val[i][31:0];
      end
      if (sel_cmp_hi[i]) begin
        prdata = cmp_val[i][63:32];
      end
    end
  end

endmodule
